// File: rtl/pipeline_pkg.sv
// Shared pipeline types: control-group structs, the holding-stage state enum
// and the reg_write qualifier applied when a beat is captured.
package pipeline_pkg;

  typedef struct packed {
    logic branch;
    logic mem_write;
    logic mem_read;
  } m_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  // A write to the hard-wired zero register is a no-op, so it is dropped
  // before it can reach the register file or the forwarding network.
  function automatic logic keep_reg_write(input logic reg_write,
                                          input logic dst_is_zero,
                                          input bit   discard_zero);
    return reg_write & ~(discard_zero & dst_is_zero);
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer: 1-cycle accept-to-output latency, 1 beat/cycle,
// in_ready is registered (low only while both entries are full); flush drops all.
module pipe_skid_buf
  import pipeline_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_t state, state_next;
  logic [W-1:0] main_q, skid_q;
  logic         accept, drain;
  logic         load_main, main_from_skid, load_skid;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;

  assign accept = in_valid & in_ready & ~flush;
  assign drain  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next     = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_next = ONE;
            load_main  = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_next = TWO;
            load_skid  = 1'b1;
          end else if (drain) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so the only move is skid -> main.
          if (drain) begin
            state_next     = ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) main_q <= main_from_skid ? skid_q : in_data;
      if (load_skid) skid_q <= in_data;
    end
  end

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM stage over a 2-entry skid buffer: bubble-gated controls, one-shot branch
// redirect; `define EX_MEM_FWD_EN adds the fwd_* forwarding tap.
module ex_mem_pipe_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W           = 32,
  parameter int PC_W             = 7,
  parameter int REG_W            = 5,
  parameter bit ZERO_REG_DISCARD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_to_reg,
  input  logic              reg_write,
  input  logic              branch,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic              zero,
  input  logic [PC_W-1:0]   pc_branch,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] data2,
  input  logic [REG_W-1:0]  dst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              mem_to_reg_o,
  output logic              reg_write_o,
  output logic              branch_o,
  output logic              mem_write_o,
  output logic              mem_read_o,
  output logic              zero_o,
  output logic [PC_W-1:0]   pc_branch_o,
  output logic [DATA_W-1:0] alu_result_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [REG_W-1:0]  dst_o,
  output logic              redirect,
  output logic [PC_W-1:0]   redirect_pc
`ifdef EX_MEM_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_dst,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  typedef struct packed {
    m_ctrl_t           m;
    wb_ctrl_t          wb;
    logic              zero;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] data2;
    logic [REG_W-1:0]  dst;
  } beat_t;

  beat_t in_beat, head;
  logic  drain, taken, redirect_done;

  always_comb begin
    in_beat              = '0;
    in_beat.m.branch     = branch;
    in_beat.m.mem_write  = mem_write;
    in_beat.m.mem_read   = mem_read;
    in_beat.wb.reg_write = keep_reg_write(reg_write, (dst == '0), ZERO_REG_DISCARD);
    in_beat.wb.mem_to_reg = mem_to_reg;
    in_beat.zero         = zero;
    in_beat.pc           = pc_branch;
    in_beat.alu          = alu_result;
    in_beat.data2        = data2;
    in_beat.dst          = dst;
  end

  pipe_skid_buf #(
    .W($bits(beat_t))
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_beat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head)
  );

  assign drain = out_valid & out_ready;

  // A bubble must never write memory or the register file.
  assign mem_to_reg_o = out_valid & head.wb.mem_to_reg;
  assign reg_write_o  = out_valid & head.wb.reg_write;
  assign branch_o     = out_valid & head.m.branch;
  assign mem_write_o  = out_valid & head.m.mem_write;
  assign mem_read_o   = out_valid & head.m.mem_read;
  assign zero_o       = out_valid & head.zero;

  assign pc_branch_o  = head.pc;
  assign alu_result_o = head.alu;
  assign data2_o      = head.data2;
  assign dst_o        = head.dst;

  // Fire once per head beat even if MEM stalls it for several cycles.
  assign taken       = out_valid & head.m.branch & head.zero;
  assign redirect    = taken & ~redirect_done & ~flush;
  assign redirect_pc = redirect ? head.pc : '0;

  always_ff @(posedge clk) begin
    if (rst || flush)   redirect_done <= 1'b0;
    else if (drain)     redirect_done <= 1'b0;
    else if (redirect)  redirect_done <= 1'b1;
  end

`ifdef EX_MEM_FWD_EN
  // Loads are excluded: their data only exists after the MEM stage.
  assign fwd_valid = reg_write_o & ~mem_to_reg_o;
  assign fwd_dst   = head.dst;
  assign fwd_data  = head.alu;
`endif

endmodule

// File: doc/ex_mem_pipe_stage.md
# ex_mem_pipe_stage

Parametrised EX→MEM pipeline stage with a valid/ready handshake, a 2-entry skid buffer, synchronous flush and a single-pulse branch redirect. Sits between the ALU/EX stage and the data-memory stage and carries the M and WB control groups plus the EX results. It also gives the hazard unit an optional forwarding tap.

## Interface
- DATA_W, 32, width of alu_result and data2
- PC_W, 7, width of pc_branch
- REG_W, 5, register-index width of dst
- ZERO_REG_DISCARD, 1, when 1 a beat with dst==0 has reg_write cleared at capture
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  kill all held and incoming beats
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- mem_to_reg, reg_write, branch, mem_write, mem_read, zero  in  1 each  EX-side control/flag
- pc_branch  in  PC_W  branch target
- alu_result, data2  in  DATA_W  EX results
- dst  in  REG_W  destination register
- out_valid  out  1  beat present at output
- out_ready  in  1  MEM stage accepts
- mem_to_reg_o, reg_write_o, branch_o, mem_write_o, mem_read_o, zero_o  out  1 each  held control; gated by out_valid
- pc_branch_o, alu_result_o, data2_o, dst_o  out  widths as inputs  held payload
- redirect  out  1  one-cycle pulse: branch taken (branch & zero) for the head beat
- redirect_pc  out  PC_W  target qualified by redirect
- fwd_valid, fwd_dst, fwd_data  out  1/REG_W/DATA_W  forwarding tap (only with EX_MEM_FWD_EN)

## Operation
- Storage: main register (drives outputs) + skid register; states EMPTY, ONE (main valid), TWO (main+skid valid).
- accept = in_valid & in_ready & !flush; drain = out_valid & out_ready.
- EMPTY: accept → ONE (beat into main).
- ONE: accept & drain → ONE (new beat into main); accept & !drain → TWO (beat into skid); drain & !accept → EMPTY.
- TWO: in_ready=0; drain → ONE (skid moves to main); no accept is possible.
- flush: next state EMPTY regardless of accept/drain; the incoming beat is discarded; payload registers keep stale data, but the valid bits clear and every control output reads 0.
- Control outputs (mem_write_o, mem_read_o, reg_write_o, mem_to_reg_o, branch_o) are ANDed with out_valid; a bubble never writes.
- ZERO_REG_DISCARD=1: reg_write is stored as reg_write & (dst!=0).
- redirect: asserted in the first cycle a beat with branch & zero is at the head; a held flag suppresses repeats while the beat stalls; the flag clears when the head advances or on flush; redirect is never asserted in a flush cycle.
- Arithmetic: none; all fields are passed through bit-exact, no width conversion.

## Timing
- Latency: 1 cycle from accept to out_valid when EMPTY (or ONE with drain).
- Throughput: 1 beat/cycle while out_ready=1.
- in_ready depends only on registered state and has no combinational path from out_ready.
- Reset: state EMPTY; in_ready=1; out_valid, redirect and fwd_valid are 0; all payload and control outputs are 0; the redirect flag is cleared. Beats presented during rst are ignored.
- Reset or flush in TWO: both entries are dropped in the next cycle; nothing is delivered.
- Simultaneous flush with drain: the drain completes in the current cycle (the MEM stage saw valid), and the stage is EMPTY in the next cycle.

## Configuration
- EX_MEM_FWD_EN defined:
  - fwd_valid = out_valid & reg_write_o & !mem_to_reg_o.
  - fwd_dst = dst_o; fwd_data = alu_result_o.
  - These outputs are combinational from the main register.
- EX_MEM_FWD_EN undefined: the fwd_* ports are absent and no forwarding logic is built.

## Structure
- Shared package pipeline_pkg holds:
  - a struct for the M group {branch, mem_write, mem_read};
  - a struct for the WB group {reg_write, mem_to_reg};
  - the state enum {EMPTY, ONE, TWO}.
- Sub-module pipe_skid_buf: a generic width-parametrised 2-entry skid buffer carrying a packed payload. The stage wraps it and adds the gating, the reg_write discard, the redirect flag and the forwarding tap.

## Test plan
- Reset, then one beat (alu_result=0x0000_00AA, dst=3, reg_write=1) with out_ready=1 → out_valid exactly one cycle later, fields match, in_ready stays 1.
- out_ready=0, present 2 beats (0x11, 0x22) → the second is accepted, then in_ready=0; release out_ready → 0x11 then 0x22 in order, with no loss or duplication.
- Flush while in TWO with in_valid=1 → the next cycle has out_valid=0, in_ready=1, all control outputs 0, and the flushed beats never appear.
- Branch beat (branch=1, zero=1, pc_branch=0x2A) held for 3 stall cycles → redirect high for exactly 1 cycle with redirect_pc=0x2A; branch=1, zero=0 → redirect never asserted.
- dst=0, reg_write=1 with ZERO_REG_DISCARD=1 → reg_write_o=0. With EX_MEM_FWD_EN, dst=7, alu_result=0x1234, reg_write=1, mem_to_reg=0 → fwd_valid=1, fwd_dst=7, fwd_data=0x1234.
- rst asserted mid-stream in TWO → the next cycle has all outputs 0 and state EMPTY; after rst drops, a fresh beat is delivered with 1-cycle latency.
